// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants, state type and helpers for the pipeline stage latch
package pipe_pkg;

    localparam int DEF_PC_W   = 32;
    localparam int DEF_OPND_W = 32;
    localparam int DEF_N_OPND = 3;
    localparam int DEF_IR_W   = 32;
    localparam int DEF_CTRL_W = 22;

    localparam logic [31:0] NOP_IR = 32'h68000000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } latch_state_t;

    // Counters wrap naturally at 2^32-1 -> 0
    function automatic logic [31:0] stat_inc(input logic [31:0] value, input logic en);
        return value + {31'd0, en};
    endfunction

endpackage

// File: rtl/pipe_stage_skid_latch_if.sv
// rtl/pipe_stage_skid_latch_if.sv - upstream/downstream handshake and payload bundle of the stage latch
interface pipe_stage_skid_latch_if
    import pipe_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int OPND_W = DEF_OPND_W,
    parameter int N_OPND = DEF_N_OPND,
    parameter int IR_W   = DEF_IR_W,
    parameter int CTRL_W = DEF_CTRL_W
);
    logic                       up_valid;
    logic                       up_ready;
    logic [PC_W-1:0]            in_pc;
    logic [PC_W-1:0]            in_bt;
    logic [N_OPND*OPND_W-1:0]   in_opnd;
    logic [IR_W-1:0]            in_ir;
    logic [CTRL_W-1:0]          in_ctrl;

    logic                       down_ready;
    logic                       out_valid;
    logic [PC_W-1:0]            out_pc;
    logic [PC_W-1:0]            out_bt;
    logic [N_OPND*OPND_W-1:0]   out_opnd;
    logic [IR_W-1:0]            out_ir;
    logic [CTRL_W-1:0]          out_ctrl;

    modport master (
        output up_valid, in_pc, in_bt, in_opnd, in_ir, in_ctrl, down_ready,
        input  up_ready, out_valid, out_pc, out_bt, out_opnd, out_ir, out_ctrl
    );

    modport slave (
        input  up_valid, in_pc, in_bt, in_opnd, in_ir, in_ctrl, down_ready,
        output up_ready, out_valid, out_pc, out_bt, out_opnd, out_ir, out_ctrl
    );

endinterface

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one payload entry register (head or skid) with load / bubble / clear controls
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int              PC_W   = DEF_PC_W,
    parameter int              OPND_W = DEF_OPND_W,
    parameter int              N_OPND = DEF_N_OPND,
    parameter int              IR_W   = DEF_IR_W,
    parameter int              CTRL_W = DEF_CTRL_W,
    parameter logic [IR_W-1:0] NOP    = pipe_pkg::NOP_IR
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      load_bubble,
    input  logic                      clear,
    input  logic [PC_W-1:0]           d_pc,
    input  logic [PC_W-1:0]           d_bt,
    input  logic [N_OPND*OPND_W-1:0]  d_opnd,
    input  logic [IR_W-1:0]           d_ir,
    input  logic [CTRL_W-1:0]         d_ctrl,
    output logic [PC_W-1:0]           q_pc,
    output logic [PC_W-1:0]           q_bt,
    output logic [N_OPND*OPND_W-1:0]  q_opnd,
    output logic [IR_W-1:0]           q_ir,
    output logic [CTRL_W-1:0]         q_ctrl
);

    // Clear beats load beats bubble; a bubble keeps the supplied pc/bt
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            q_pc   <= '0;
            q_bt   <= '0;
            q_opnd <= '0;
            q_ir   <= NOP;
            q_ctrl <= '0;
        end else if (clear) begin
            q_pc   <= '0;
            q_bt   <= '0;
            q_opnd <= '0;
            q_ir   <= NOP;
            q_ctrl <= '0;
        end else if (load) begin
            q_pc   <= d_pc;
            q_bt   <= d_bt;
            q_opnd <= d_opnd;
            q_ir   <= d_ir;
            q_ctrl <= d_ctrl;
        end else if (load_bubble) begin
            q_pc   <= d_pc;
            q_bt   <= d_bt;
            q_opnd <= '0;
            q_ir   <= NOP;
            q_ctrl <= '0;
        end
    end

endmodule

// File: rtl/pipe_stage_skid_latch.sv
// rtl/pipe_stage_skid_latch.sv - inter-stage latch with 2-entry skid, bubble insert, flush; PIPE_LATCH_STATS_EN enables counters
module pipe_stage_skid_latch
    import pipe_pkg::*;
#(
    parameter int              PC_W   = DEF_PC_W,
    parameter int              OPND_W = DEF_OPND_W,
    parameter int              N_OPND = DEF_N_OPND,
    parameter int              IR_W   = DEF_IR_W,
    parameter int              CTRL_W = DEF_CTRL_W,
    parameter logic [IR_W-1:0] NOP_IR = pipe_pkg::NOP_IR
) (
    input  logic                     clk,
    input  logic                     rst,
    pipe_stage_skid_latch_if.slave   bus,
    input  logic                     data_interlock,
    input  logic                     branch_interlock,
    input  logic                     flush,
    output logic [31:0]              stat_bubbles,
    output logic [31:0]              stat_stalls,
    output logic [31:0]              stat_flushes
);

    localparam int OW = N_OPND * OPND_W;

    latch_state_t state, next_state;

    logic il, space, accept, bubble, enq, pop;
    logic head_load, head_bubble, head_clear, head_sel_skid;
    logic skid_load, skid_bubble, skid_clear;

    logic [PC_W-1:0]   tail_pc, tail_bt, enq_pc, enq_bt;
    logic [PC_W-1:0]   skid_pc, skid_bt, head_d_pc, head_d_bt;
    logic [OW-1:0]     skid_opnd, head_d_opnd;
    logic [IR_W-1:0]   skid_ir, head_d_ir;
    logic [CTRL_W-1:0] skid_ctrl, head_d_ctrl;

    assign il     = data_interlock | branch_interlock;
    assign space  = (state != TWO);
    assign accept = bus.up_valid & bus.up_ready & ~il & ~flush;
    assign bubble = il & space & ~flush;
    assign enq    = accept | bubble;
    assign pop    = bus.out_valid & bus.down_ready;

    assign bus.out_valid = (state != EMPTY);

    // A bubble repeats the pc/bt of the most recent real enqueue
    assign enq_pc = bubble ? tail_pc : bus.in_pc;
    assign enq_bt = bubble ? tail_bt : bus.in_bt;

    assign head_d_pc   = head_sel_skid ? skid_pc   : enq_pc;
    assign head_d_bt   = head_sel_skid ? skid_bt   : enq_bt;
    assign head_d_opnd = head_sel_skid ? skid_opnd : bus.in_opnd;
    assign head_d_ir   = head_sel_skid ? skid_ir   : bus.in_ir;
    assign head_d_ctrl = head_sel_skid ? skid_ctrl : bus.in_ctrl;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (enq) next_state = ONE;
                ONE: begin
                    if (enq && !pop)      next_state = TWO;
                    else if (!enq && pop) next_state = EMPTY;
                end
                TWO:     if (pop) next_state = ONE;
                default: next_state = EMPTY;
            endcase
        end
    end

    always_comb begin
        head_load     = 1'b0;
        head_bubble   = 1'b0;
        head_clear    = flush;
        head_sel_skid = 1'b0;
        skid_load     = 1'b0;
        skid_bubble   = 1'b0;
        skid_clear    = flush;
        if (!flush) begin
            case (state)
                EMPTY: begin
                    head_load   = accept;
                    head_bubble = bubble;
                end
                ONE: begin
                    if (enq && pop) begin
                        head_load   = accept;
                        head_bubble = bubble;
                    end else if (enq) begin
                        skid_load   = accept;
                        skid_bubble = bubble;
                    end else if (pop) begin
                        head_clear  = 1'b1;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_load     = 1'b1;
                        head_sel_skid = 1'b1;
                    end
                end
                default: head_clear = 1'b1;
            endcase
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            bus.up_ready <= 1'b1;
        end else begin
            bus.up_ready <= (next_state != TWO);
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            tail_pc <= '0;
            tail_bt <= '0;
        end else if (accept) begin
            tail_pc <= bus.in_pc;
            tail_bt <= bus.in_bt;
        end
    end

    pipe_entry_reg #(
        .PC_W(PC_W), .OPND_W(OPND_W), .N_OPND(N_OPND),
        .IR_W(IR_W), .CTRL_W(CTRL_W), .NOP(NOP_IR)
    ) u_head (
        .clk        (clk),
        .rst        (rst),
        .load       (head_load),
        .load_bubble(head_bubble),
        .clear      (head_clear),
        .d_pc       (head_d_pc),
        .d_bt       (head_d_bt),
        .d_opnd     (head_d_opnd),
        .d_ir       (head_d_ir),
        .d_ctrl     (head_d_ctrl),
        .q_pc       (bus.out_pc),
        .q_bt       (bus.out_bt),
        .q_opnd     (bus.out_opnd),
        .q_ir       (bus.out_ir),
        .q_ctrl     (bus.out_ctrl)
    );

    pipe_entry_reg #(
        .PC_W(PC_W), .OPND_W(OPND_W), .N_OPND(N_OPND),
        .IR_W(IR_W), .CTRL_W(CTRL_W), .NOP(NOP_IR)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .load_bubble(skid_bubble),
        .clear      (skid_clear),
        .d_pc       (enq_pc),
        .d_bt       (enq_bt),
        .d_opnd     (bus.in_opnd),
        .d_ir       (bus.in_ir),
        .d_ctrl     (bus.in_ctrl),
        .q_pc       (skid_pc),
        .q_bt       (skid_bt),
        .q_opnd     (skid_opnd),
        .q_ir       (skid_ir),
        .q_ctrl     (skid_ctrl)
    );

`ifdef PIPE_LATCH_STATS_EN
    logic stall_evt;

    // An interlock that finds no room also holds upstream, so it counts as a stall
    assign stall_evt = (bus.out_valid & ~bus.down_ready) | (il & (state == TWO));

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            stat_bubbles <= '0;
            stat_stalls  <= '0;
            stat_flushes <= '0;
        end else begin
            stat_bubbles <= stat_inc(stat_bubbles, bubble);
            stat_stalls  <= stat_inc(stat_stalls, stall_evt);
            stat_flushes <= stat_inc(stat_flushes, flush);
        end
    end
`else
    assign stat_bubbles = '0;
    assign stat_stalls  = '0;
    assign stat_flushes = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_latch.sv
// tb/tb_pipe_stage_skid_latch.sv - directed and randomized checks of the stage latch against a queue model
module tb_pipe_stage_skid_latch;
    import pipe_pkg::*;

    localparam int PC_W = 32, OPND_W = 32, N_OPND = 3, IR_W = 32, CTRL_W = 22;
    localparam int OW = N_OPND * OPND_W;
`ifdef PIPE_LATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic data_interlock = 1'b0, branch_interlock = 1'b0, flush = 1'b0;
    logic [31:0] stat_bubbles, stat_stalls, stat_flushes;

    pipe_stage_skid_latch_if #(.PC_W(PC_W), .OPND_W(OPND_W), .N_OPND(N_OPND),
                               .IR_W(IR_W), .CTRL_W(CTRL_W)) bus ();

    pipe_stage_skid_latch #(.PC_W(PC_W), .OPND_W(OPND_W), .N_OPND(N_OPND),
                            .IR_W(IR_W), .CTRL_W(CTRL_W), .NOP_IR(NOP_IR)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .data_interlock  (data_interlock),
        .branch_interlock(branch_interlock),
        .flush           (flush),
        .stat_bubbles    (stat_bubbles),
        .stat_stalls     (stat_stalls),
        .stat_flushes    (stat_flushes)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   bt;
        logic [OW-1:0]     opnd;
        logic [IR_W-1:0]   ir;
        logic [CTRL_W-1:0] ctrl;
    } ent_t;

    ent_t        q[$];
    logic [31:0] tail_pc, tail_bt;
    int unsigned n_bub, n_stall, n_flush;
    bit          consumed = 1'b0;
    int          n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        tail_pc = '0;
        tail_bt = '0;
        n_bub   = 0;
        n_stall = 0;
        n_flush = 0;
    endtask

    // Capacity-2 FIFO: pop the head, then append either a bubble or the offered payload
    task automatic model_edge();
        int   n;
        bit   il;
        ent_t e;
        n  = q.size();
        il = data_interlock | branch_interlock;
        consumed = 1'b0;
        if ((n > 0 && !bus.down_ready) || (il && n == 2)) n_stall++;
        if (flush) begin
            n_flush++;
            q.delete();
        end else begin
            if (n > 0 && bus.down_ready) void'(q.pop_front());
            if (il && n < 2) begin
                e.pc = tail_pc; e.bt = tail_bt; e.opnd = '0; e.ir = NOP_IR; e.ctrl = '0;
                q.push_back(e);
                n_bub++;
            end else if (!il && bus.up_valid && n < 2) begin
                e.pc = bus.in_pc; e.bt = bus.in_bt; e.opnd = bus.in_opnd;
                e.ir = bus.in_ir; e.ctrl = bus.in_ctrl;
                tail_pc = bus.in_pc;
                tail_bt = bus.in_bt;
                q.push_back(e);
                consumed = 1'b1;
            end
        end
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_bubbles"}, 128'(stat_bubbles), STATS ? 128'(n_bub)   : 128'(0));
        check({tag, "_stalls"},  128'(stat_stalls),  STATS ? 128'(n_stall) : 128'(0));
        check({tag, "_flushes"}, 128'(stat_flushes), STATS ? 128'(n_flush) : 128'(0));
    endtask

    task automatic check_outputs();
        check("out_valid", 128'(bus.out_valid), 128'(q.size() > 0));
        check("up_ready",  128'(bus.up_ready),  128'(q.size() < 2));
        if (q.size() > 0) begin
            check("out_ir",   128'(bus.out_ir),   128'(q[0].ir));
            check("out_ctrl", 128'(bus.out_ctrl), 128'(q[0].ctrl));
            check("out_pc",   128'(bus.out_pc),   128'(q[0].pc));
            check("out_bt",   128'(bus.out_bt),   128'(q[0].bt));
            check("out_opnd", 128'(bus.out_opnd), 128'(q[0].opnd));
        end
        check_stats("stat");
    endtask

    task automatic step();
        @(negedge clk);
        if (!rst) model_edge();
        @(posedge clk);
        check_outputs();
    endtask

    task automatic new_payload(input logic [IR_W-1:0] ir);
        bus.in_pc   = $urandom;
        bus.in_bt   = $urandom;
        bus.in_opnd = OW'({$urandom, $urandom, $urandom});
        bus.in_ir   = ir;
        bus.in_ctrl = CTRL_W'($urandom);
    endtask

    task automatic put(input bit uv, input logic [IR_W-1:0] ir, input bit dr);
        new_payload(ir);
        bus.up_valid   = uv;
        bus.down_ready = dr;
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b1;
        model_reset();
        #2 rst = 1'b0;
    endtask

    initial begin
        bus.up_valid = 1'b0;
        bus.down_ready = 1'b0;
        new_payload('0);
        model_reset();

        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_up_ready",  128'(bus.up_ready),  128'(1));
        check("rst_out_ir",    128'(bus.out_ir),    128'(32'h68000000));
        check("rst_out_ctrl",  128'(bus.out_ctrl),  128'(0));
        check_stats("rst");
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);

        // single transfer, latency of one falling edge
        put(1, 32'h12345678, 1);
        step();
        check("t1_ir",    128'(bus.out_ir),    128'(32'h12345678));
        check("t1_valid", 128'(bus.out_valid), 128'(1));
        check("t1_ready", 128'(bus.up_ready),  128'(1));
        put(0, '0, 1);
        step();

        // fill head and skid while stalled, then drain in order
        put(1, 32'hA, 0);
        step();
        put(1, 32'hB, 0);
        step();
        check("t2_ready_full", 128'(bus.up_ready), 128'(0));
        check("t2_head_a",     128'(bus.out_ir),   128'(32'hA));
        put(0, '0, 0);
        step();
        check("t2_hold_a",     128'(bus.out_ir),   128'(32'hA));
        put(0, '0, 1);
        step();
        check("t2_head_b",     128'(bus.out_ir),   128'(32'hB));
        check("t2_ready_back", 128'(bus.up_ready), 128'(1));
        step();
        check("t2_drained",    128'(bus.out_valid), 128'(0));

        // interlock inserts a bubble ahead of the held payload
        put(1, 32'hC, 1);
        data_interlock = 1'b1;
        step();
        check("t3_bubble_ir",   128'(bus.out_ir),   128'(32'h68000000));
        check("t3_bubble_ctrl", 128'(bus.out_ctrl), 128'(0));
        data_interlock = 1'b0;
        step();
        check("t3_after_ir",    128'(bus.out_ir),   128'(32'hC));
        put(0, '0, 1);
        step();

        // flush from TWO drops both entries and the offered input
        put(1, 32'hD1, 0);
        step();
        put(1, 32'hD2, 0);
        step();
        put(1, 32'hE0, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t4_valid", 128'(bus.out_valid), 128'(0));
        check("t4_ir",    128'(bus.out_ir),    128'(32'h68000000));
        check("t4_ready", 128'(bus.up_ready),  128'(1));
        put(0, '0, 1);
        step();
        check("t4_gone",  128'(bus.out_valid), 128'(0));

        // counter scenario: 3 bubbles, 4 stalls, 1 flush
        pulse_reset();
        put(0, '0, 1);
        data_interlock = 1'b1;
        repeat (3) step();
        data_interlock = 1'b0;
        bus.down_ready = 1'b0;
        repeat (4) step();
        bus.down_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t6_bubbles", 128'(stat_bubbles), STATS ? 128'(3) : 128'(0));
        check("t6_stalls",  128'(stat_stalls),  STATS ? 128'(4) : 128'(0));
        check("t6_flushes", 128'(stat_flushes), STATS ? 128'(1) : 128'(0));

        // asynchronous reset while holding one entry
        put(1, 32'h55, 0);
        step();
        put(0, '0, 0);
        #2 rst = 1'b1;
        #1;
        check("t5_valid", 128'(bus.out_valid), 128'(0));
        check("t5_ir",    128'(bus.out_ir),    128'(32'h68000000));
        check("t5_ready", 128'(bus.up_ready),  128'(1));
        model_reset();
        check_stats("t5");
        #1 rst = 1'b0;

        // randomized traffic, upstream holds its payload until consumed
        for (int i = 0; i < 1500; i++) begin
            if (consumed || !bus.up_valid) begin
                new_payload(IR_W'($urandom));
                bus.up_valid = ($urandom_range(0, 3) != 0);
            end
            data_interlock   = ($urandom_range(0, 9) == 0);
            branch_interlock = ($urandom_range(0, 19) == 0);
            flush            = ($urandom_range(0, 29) == 0);
            bus.down_ready   = ($urandom_range(0, 9) < 6);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
